mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Burst access controller directly upstream of the 16 KiB word memory (mem16k).
- Converts a byte-addressed request/ack command plus valid/ready data streams into the memory's single-port word interface: addr, write_en, wdata, combinational rdata.
- Sits between generated datapath logic (or a bus bridge) and mem16k; one burst in flight at a time.

Parameters:
- ADDR_W, 30, word-address width driven to memory.
- LEN_W, 4, burst length field width; burst = req_len_i+1 words (max 16 at default).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  command request; held until req_ack_o.
- req_wr_i  in  1  1 = write burst, 0 = read burst.
- req_addr_i  in  ADDR_W+2  byte address; bits [1:0] ignored.
- req_len_i  in  LEN_W  burst length minus one.
- req_ack_o  out  1  one-cycle command accept pulse.
- wdata_i  in  32  write beat data.
- wvalid_i  in  1  write beat valid.
- wready_o  out  1  controller can take a write beat.
- rdata_o  out  32  read beat data.
- rvalid_o  out  1  read beat valid.
- rready_i  in  1  consumer takes read beat.
- done_o  out  1  one-cycle pulse after last beat of burst.
- mem_addr_o  out  ADDR_W  word address to memory.
- mem_write_en_o  out  1  memory write strobe.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data (combinational from mem_addr_o).

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers: state, waddr (ADDR_W), cnt (LEN_W), all reset to 0 / IDLE.
- Reset values: req_ack_o=0, wready_o=0, rvalid_o=0, done_o=0, mem_write_en_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
- IDLE: when req_i=1, req_ack_o=1 for that cycle. Latch waddr=req_addr_i[ADDR_W+1:2] and cnt=req_len_i. Next state is WRITE if req_wr_i=1, else READ. When req_i=0, stay in IDLE.
- READ: rvalid_o=1 and rdata_o=mem_rdata_i for mem_addr_o=waddr. This gives zero-latency data through the memory, so the first beat is valid in the cycle after ack. A beat completes when rready_i=1. If cnt==0, go to DONE; else waddr+1, cnt-1. While rready_i=0, rdata_o and waddr hold.
- WRITE: wready_o=1. mem_write_en_o=wvalid_i, mem_wdata_o=wdata_i, mem_addr_o=waddr. On a beat (wvalid_i=1), apply the same counting and transition rule as READ. While wvalid_i=0, no write occurs and state holds.
- DONE: done_o=1 for one cycle, then IDLE. req_i is ignored in DONE, so the earliest next ack is the cycle after DONE.
- Outside its active state, each of rvalid_o/wready_o/mem_write_en_o is 0. mem_addr_o shows waddr in all states.
- Wrap-around: waddr increments modulo 2^ADDR_W. The memory decodes addr[11:0], so bursts physically wrap at 4096 words; no error is flagged.
- Length 0 (req_len_i=0): exactly one beat, then DONE.
- Reset mid-burst: the burst is aborted and state returns to IDLE. mem_write_en_o is gated by !rst_i, so no write occurs in the reset cycle. No done_o is issued for an aborted burst.
- Simultaneous events: wvalid_i while in READ is ignored. rready_i while not in READ is ignored.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_BYTE_EN_EN.
- Defined: adds port wstrb_i in 4 (byte lane enables for the write beat). mem_wdata_o byte k = wstrb_i[k] ? wdata_i byte k : mem_rdata_i byte k. This is a read-modify-write in the same cycle, with no added latency, because memory read is combinational. If wstrb_i=0000 on a valid beat, the beat is still consumed and counted, but mem_write_en_o=0.
- Undefined: no wstrb_i port; full-word writes only.

Decomposition:
- Package mem_access_pkg: state encoding constants (IDLE=0, READ=1, WRITE=2, DONE=3) and the byte-merge function (wdata, rdata, strb -> merged word).
- No sub-module needed. Optionally, mem_byte_merge can be a combinational leaf used only under MEM_ACCESS_CTRL_BYTE_EN_EN.

Test Plan:
- Write burst: addr=0x100, len=3, data 0x11..0x44 with wvalid_i always 1. Expect ack in cycle 0, four writes to word addresses 0x40..0x43 in cycles 1-4, done_o in cycle 5.
- Read back with rready_i toggling 1,0,1,0: rdata_o=0x11,0x22,0x33,0x44 in order; data holds during stalls; done_o one cycle after the last accepted beat.
- Wrap: write len=1 at byte addr 0x3FFC. Expect word 0xFFF then mem_addr_o=0x1000; memory stores the second word at index 0. Read at 0x0 returns it.
- Reset mid-burst: assert rst_i during the third beat of a len=7 write. Expect no write in the reset cycle, all outputs 0, IDLE afterwards, and no done_o.
- Back-to-back: req_i held high across two commands. Expect the second ack two cycles after the first burst's last beat (after DONE), not during DONE.
- BYTE_EN (macro defined): memory word = 0xAABBCCDD; write 0x11223344 with wstrb_i=0101. Expect 0xAA22CC44 stored. With wstrb_i=0000, expect the beat consumed and no write.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the burst memory access controller.
// Optional byte-lane writes are enabled with MEM_ACCESS_CTRL_BYTE_EN_EN.
package mem_access_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Take enabled byte lanes from the new word, the rest from the stored word.
   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] wdata,
                                                    input logic [DATA_W-1:0] rdata,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] merged;
      merged = rdata;
      for (int k = 0; k < int'(STRB_W); k++) begin
         if (strb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Command, data-stream and memory-side signals of mem_access_ctrl.
// wstrb_i exists only when MEM_ACCESS_CTRL_BYTE_EN_EN is defined.
interface mem_access_if #(
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned LEN_W  = 4
);
   import mem_access_pkg::*;

   logic                req_i;
   logic                req_wr_i;
   logic [ADDR_W+1:0]   req_addr_i;
   logic [LEN_W-1:0]    req_len_i;
   logic                req_ack_o;
   logic [DATA_W-1:0]   wdata_i;
   logic                wvalid_i;
   logic                wready_o;
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
   logic [STRB_W-1:0]   wstrb_i;
`endif
   logic [DATA_W-1:0]   rdata_o;
   logic                rvalid_o;
   logic                rready_i;
   logic                done_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic                mem_write_en_o;
   logic [DATA_W-1:0]   mem_wdata_o;
   logic [DATA_W-1:0]   mem_rdata_i;

   // Controller side.
   modport slave (
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
      input  wstrb_i,
`endif
      input  req_i, req_wr_i, req_addr_i, req_len_i,
      input  wdata_i, wvalid_i, rready_i, mem_rdata_i,
      output req_ack_o, wready_o, rdata_o, rvalid_o, done_o,
      output mem_addr_o, mem_write_en_o, mem_wdata_o
   );

   // Requester and memory side.
   modport master (
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
      output wstrb_i,
`endif
      output req_i, req_wr_i, req_addr_i, req_len_i,
      output wdata_i, wvalid_i, rready_i, mem_rdata_i,
      input  req_ack_o, wready_o, rdata_o, rvalid_o, done_o,
      input  mem_addr_o, mem_write_en_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_access_ctrl.sv
// Burst access controller in front of the single-port word memory.
// Memory read data is combinational, so read beats and byte-lane merges
// pass straight through in the cycle the address is presented.
// Define MEM_ACCESS_CTRL_BYTE_EN_EN for byte-lane write enables.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned LEN_W  = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mem_access_if.slave    bus
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                beat;
   logic [DATA_W-1:0]   wr_word;
   logic                wr_any;
   logic                unused_addr_lsb;

   // Byte offset bits of the command address carry no information.
   assign unused_addr_lsb = ^bus.req_addr_i[1:0];

   // A beat completes when the stream of the active direction handshakes.
   assign beat = ((state_q == READ)  && bus.rready_i) ||
                 ((state_q == WRITE) && bus.wvalid_i);

   // Word presented to memory and whether any lane is actually written.
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
   assign wr_word = byte_merge(bus.wdata_i, bus.mem_rdata_i, bus.wstrb_i);
   assign wr_any  = |bus.wstrb_i;
`else
   assign wr_word = bus.wdata_i;
   assign wr_any  = 1'b1;
`endif

   // Next-state: accept a command, then walk the burst one beat at a time.
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               waddr_d = bus.req_addr_i[ADDR_W+1:2];
               cnt_d   = bus.req_len_i;
               state_d = bus.req_wr_i ? WRITE : READ;
            end
         end
         READ, WRITE: begin
            if (beat) begin
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  waddr_d = waddr_q + ADDR_W'(1);
                  cnt_d   = cnt_q - LEN_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and burst registers; reset aborts any burst in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         waddr_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output decode; everything is forced quiet while reset is asserted.
   always_comb begin
      bus.req_ack_o      = 1'b0;
      bus.wready_o       = 1'b0;
      bus.rvalid_o       = 1'b0;
      bus.rdata_o        = '0;
      bus.done_o         = 1'b0;
      bus.mem_addr_o     = '0;
      bus.mem_write_en_o = 1'b0;
      bus.mem_wdata_o    = '0;
      if (!rst_i) begin
         bus.mem_addr_o = waddr_q;
         case (state_q)
            IDLE:  bus.req_ack_o = bus.req_i;
            READ: begin
               bus.rvalid_o = 1'b1;
               bus.rdata_o  = bus.mem_rdata_i;
            end
            WRITE: begin
               bus.wready_o       = 1'b1;
               bus.mem_wdata_o    = wr_word;
               bus.mem_write_en_o = bus.wvalid_i && wr_any;
            end
            DONE:    bus.done_o = 1'b1;
            default: bus.done_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural 4096-word memory.
// Define MEM_ACCESS_CTRL_BYTE_EN_EN to also exercise byte-lane writes.
module tb_mem_access_ctrl;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned LEN_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Physical memory: decodes addr[11:0], combinational read, clocked write.
   logic [31:0] mem [4096];
   assign bus.mem_rdata_i = mem[bus.mem_addr_o[11:0]];
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      forever begin
         @(posedge clk);
         if (bus.mem_write_en_o) mem[bus.mem_addr_o[11:0]] <= bus.mem_wdata_o;
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   function automatic logic [3:0] strb_of();
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
      return bus.wstrb_i;
`else
      return 4'hF;
`endif
   endfunction

   function automatic logic [31:0] lane_mix(input logic [31:0] nw, input logic [31:0] old, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (nw & mask) | (old & ~mask);
   endfunction

   // Transaction-level model: a burst is "beats remaining" at a current word.
   logic [31:0] ref_mem [4096];
   bit          m_busy, m_wr, m_done;
   int          m_left;
   logic [29:0] m_addr;

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      m_busy = 0; m_wr = 0; m_done = 0; m_left = 0; m_addr = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_busy = 0; m_done = 0; m_left = 0; m_addr = '0;
         end else if (m_done) begin
            m_done = 0;
         end else if (!m_busy) begin
            if (bus.req_i) begin
               m_busy = 1;
               m_wr   = bus.req_wr_i;
               m_addr = bus.req_addr_i[31:2];
               m_left = int'(bus.req_len_i) + 1;
            end
         end else if (m_wr ? bus.wvalid_i : bus.rready_i) begin
            if (m_wr && strb_of() != 4'h0)
               ref_mem[m_addr[11:0]] = lane_mix(bus.wdata_i, ref_mem[m_addr[11:0]], strb_of());
            m_left--;
            if (m_left == 0) begin
               m_busy = 0;
               m_done = 1;
            end else begin
               m_addr = m_addr + 30'd1;
            end
         end
      end
   end

   // Every cycle: DUT outputs against the model, sampled mid-cycle.
   always @(negedge clk) begin
      logic        e_ack, e_rv, e_wr, e_done, e_we;
      logic [31:0] e_rd, e_wd;
      logic [29:0] e_addr;
      e_ack  = !rst && !m_busy && !m_done && bus.req_i;
      e_rv   = !rst && m_busy && !m_wr;
      e_wr   = !rst && m_busy && m_wr;
      e_done = !rst && m_done;
      e_addr = rst ? 30'd0 : m_addr;
      e_we   = e_wr && bus.wvalid_i && (strb_of() != 4'h0);
      e_wd   = e_wr ? lane_mix(bus.wdata_i, ref_mem[m_addr[11:0]], strb_of()) : 32'h0;
      e_rd   = e_rv ? ref_mem[m_addr[11:0]] : 32'h0;
      chk("req_ack_o",      32'(bus.req_ack_o),      32'(e_ack));
      chk("rvalid_o",       32'(bus.rvalid_o),       32'(e_rv));
      chk("wready_o",       32'(bus.wready_o),       32'(e_wr));
      chk("done_o",         32'(bus.done_o),         32'(e_done));
      chk("mem_addr_o",     32'(bus.mem_addr_o),     32'(e_addr));
      chk("mem_write_en_o", 32'(bus.mem_write_en_o), 32'(e_we));
      chk("mem_wdata_o",    bus.mem_wdata_o,         e_wd);
      chk("rdata_o",        bus.rdata_o,             e_rd);
   end

   // Event logs for the hand-computed timing checks.
   int          ack_cyc[$], done_cyc[$], wl_cyc[$];
   logic [29:0] wl_addr[$];
   logic [31:0] wl_data[$];
   always @(negedge clk) begin
      if (bus.req_ack_o) ack_cyc.push_back(cyc);
      if (bus.done_o)    done_cyc.push_back(cyc);
      if (bus.mem_write_en_o) begin
         wl_cyc.push_back(cyc);
         wl_addr.push_back(bus.mem_addr_o);
         wl_data.push_back(bus.mem_wdata_o);
      end
   end

   task automatic cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len, input bit hold);
      int n = 0;
      bus.req_i = 1'b1; bus.req_wr_i = wr; bus.req_addr_i = addr; bus.req_len_i = len;
      #1;
      while (!bus.req_ack_o && n < 20) begin @(posedge clk); #2; n++; end
      chk("ack_timeout", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      if (!hold) bus.req_i = 1'b0;
   endtask

   task automatic wbeat(input logic [31:0] d);
      int n = 0;
      bus.wvalid_i = 1'b1; bus.wdata_i = d;
      #1;
      while (!bus.wready_o && n < 20) begin @(posedge clk); #2; n++; end
      chk("wready_timeout", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      bus.wvalid_i = 1'b0;
   endtask

   task automatic rbeat(output logic [31:0] d);
      int n = 0;
      bus.rready_i = 1'b1;
      #1;
      while (!bus.rvalid_o && n < 20) begin @(posedge clk); #2; n++; end
      chk("rvalid_timeout", 32'(n < 20), 32'd1);
      d = bus.rdata_o;
      @(posedge clk); #1;
      bus.rready_i = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      int base = done_cyc.size();
      while (done_cyc.size() == base && n < 30) begin @(posedge clk); #1; n++; end
      chk("done_timeout", 32'(n < 30), 32'd1);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] wdat [4];
      int a0, d0, w0;
      wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
      bus.req_i = 0; bus.req_wr_i = 0; bus.req_addr_i = '0; bus.req_len_i = '0;
      bus.wdata_i = '0; bus.wvalid_i = 0; bus.rready_i = 0;
`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
      bus.wstrb_i = 4'hF;
`endif
      repeat (3) @(posedge clk);
      #2;
      chk("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
      chk("reset_addr",   32'(bus.mem_addr_o), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Write burst 0x100, len 3: writes 0x40..0x43 in ack+1..ack+4, done at ack+5.
      a0 = ack_cyc.size(); d0 = done_cyc.size(); w0 = wl_cyc.size();
      cmd(1'b1, 32'h100, 4'd3, 1'b0);
      for (int i = 0; i < 4; i++) wbeat(wdat[i]);
      wait_done();
      chk("wr_count", 32'(wl_cyc.size() - w0), 32'd4);
      if (wl_cyc.size() - w0 == 4 && ack_cyc.size() > a0 && done_cyc.size() > d0) begin
         for (int i = 0; i < 4; i++) begin
            chk("wr_addr",  32'(wl_addr[w0+i]), 32'h40 + 32'(i));
            chk("wr_cycle", 32'(wl_cyc[w0+i] - ack_cyc[a0]), 32'(i + 1));
         end
         chk("wr_done_cycle", 32'(done_cyc[d0] - ack_cyc[a0]), 32'd5);
      end
      chk("mem_40", mem[12'h040], 32'h11);
      chk("mem_43", mem[12'h043], 32'h44);

      // Read back with rready toggling; data holds across stalls.
      cmd(1'b0, 32'h100, 4'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         rbeat(v);
         chk("rd_beat", v, wdat[i]);
         #1;
         if (i < 3) begin
            chk("rd_stall_valid", 32'(bus.rvalid_o), 32'd1);
            chk("rd_stall_hold",  bus.rdata_o, wdat[i+1]);
            @(posedge clk); #1;
         end else begin
            chk("rd_done_next", 32'(bus.done_o), 32'd1);
            @(posedge clk); #1;
         end
      end

      // Wrap: words 0xFFF then 0x1000, which lands on physical index 0.
      w0 = wl_cyc.size();
      cmd(1'b1, 32'h3FFC, 4'd1, 1'b0);
      wbeat(32'hA5A5_0001);
      wbeat(32'hA5A5_0002);
      wait_done();
      chk("wrap_count", 32'(wl_cyc.size() - w0), 32'd2);
      if (wl_cyc.size() - w0 == 2) begin
         chk("wrap_addr0", 32'(wl_addr[w0]),   32'h0000_0FFF);
         chk("wrap_addr1", 32'(wl_addr[w0+1]), 32'h0000_1000);
      end
      chk("wrap_mem_fff", mem[12'hFFF], 32'hA5A5_0001);
      chk("wrap_mem_0",   mem[12'h000], 32'hA5A5_0002);
      cmd(1'b0, 32'h0, 4'd0, 1'b0);
      rbeat(v);
      chk("wrap_readback", v, 32'hA5A5_0002);
      wait_done();

      // Reset during the third beat of a len=7 write at word 0x80.
      w0 = wl_cyc.size(); d0 = done_cyc.size();
      cmd(1'b1, 32'h200, 4'd7, 1'b0);
      wbeat(32'hC0DE_0001);
      wbeat(32'hC0DE_0002);
      bus.wvalid_i = 1'b1; bus.wdata_i = 32'hC0DE_0003; rst = 1'b1;
      #1;
      chk("rst_no_write", 32'(bus.mem_write_en_o), 32'd0);
      chk("rst_wready",   32'(bus.wready_o), 32'd0);
      chk("rst_addr",     32'(bus.mem_addr_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; bus.wvalid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_writes",  32'(wl_cyc.size() - w0), 32'd2);
      chk("rst_no_done", 32'(done_cyc.size() - d0), 32'd0);
      chk("rst_mem_82",  mem[12'h082], 32'h0);

      // Back-to-back with req_i held: second ack two cycles after the last beat.
      a0 = ack_cyc.size(); w0 = wl_cyc.size();
      cmd(1'b1, 32'h300, 4'd0, 1'b1);
      bus.req_wr_i = 1'b0;
      wbeat(32'hBEEF_0300);
      #1;
      chk("b2b_no_ack_in_done", 32'(bus.req_ack_o), 32'd0);
      cmd(1'b0, 32'h300, 4'd0, 1'b0);
      chk("b2b_acks", 32'(ack_cyc.size() - a0), 32'd2);
      if (ack_cyc.size() - a0 == 2 && wl_cyc.size() > w0) begin
         chk("b2b_ack_gap",   32'(ack_cyc[a0+1] - ack_cyc[a0]), 32'd3);
         chk("b2b_after_beat", 32'(ack_cyc[a0+1] - wl_cyc[w0]), 32'd2);
      end
      rbeat(v);
      chk("b2b_readback", v, 32'hBEEF_0300);
      wait_done();

`ifdef MEM_ACCESS_CTRL_BYTE_EN_EN
      // Byte lanes: 0xAABBCCDD merged with 0x11223344 under 0101.
      cmd(1'b1, 32'h400, 4'd0, 1'b0);
      wbeat(32'hAABB_CCDD);
      wait_done();
      cmd(1'b1, 32'h400, 4'd0, 1'b0);
      bus.wstrb_i = 4'b0101;
      wbeat(32'h1122_3344);
      bus.wstrb_i = 4'hF;
      wait_done();
      chk("be_merge", mem[12'h100], 32'hAA22_CC44);
      w0 = wl_cyc.size();
      cmd(1'b1, 32'h400, 4'd0, 1'b0);
      bus.wstrb_i = 4'b0000;
      wbeat(32'hFFFF_FFFF);
      bus.wstrb_i = 4'hF;
      wait_done();
      chk("be_zero_nowrite", 32'(wl_cyc.size() - w0), 32'd0);
      chk("be_zero_keep", mem[12'h100], 32'hAA22_CC44);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
